// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
//  - state_e   : controller FSM states
//  - WidthMin/WidthMax : legal range of the WIDTH parameter
package serial_add_pkg;

  localparam int unsigned WidthMin = 1;
  localparam int unsigned WidthMax = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
//  a, b, cin : addend bits and carry in
//  sum, cout : sum bit and carry out
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (p & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer. Operands are accepted on an in_valid/in_ready handshake,
// added LSB-first through a single full_adder_cell (one bit per clock), and the result is
// offered on an out_valid/out_ready handshake.
//  clk, rst             : clock, asynchronous active-high reset
//  in_valid/in_ready    : operand handshake (ready only in IDLE)
//  a, b, cin            : operands and carry in, sampled on accept
//  out_valid/out_ready  : result handshake (valid only in DONE)
//  sum, cout, ovf       : result, carry out of MSB, signed overflow
//  busy                 : job in progress or result pending
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_sr_q;
  logic             carry_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic             fa_s;
  logic             fa_c;
  // New sum bit enters at the MSB; the concatenation keeps this legal for WIDTH=1.
  logic [WIDTH:0]   sum_cat;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign sum_cat = {fa_s, sum_sr_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sr_q   <= a;
            b_sr_q   <= b;
            carry_q  <= cin;
            cnt_q    <= '0;
            sum_sr_q <= '0;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sr_q <= sum_cat[WIDTH:1];
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LastBit) begin
            // carry_q is the carry into the MSB at this point
            ovf_q   <= carry_q ^ fa_c;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum       = sum_sr_q;
  assign cout      = carry_q;
  assign ovf       = ovf_q;

endmodule
